// File: rtl/dispatch_window_reader_pkg.sv
// Shared constants and packet layout for the instruction-buffer dispatch interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dispatch_window_reader_pkg;

    localparam int PKT_W          = 151;
    localparam int DISPATCH_WIDTH = 4;
    localparam int BRANCH_CNT_W   = 3;
    localparam int CKPT_COUNT     = 8;
    localparam int CKPT_W         = $clog2(CKPT_COUNT) + 1;
    localparam int FREE_W         = 7;

    // Decoded packet layout, MSB first; must stay in step with the instruction buffer.
    typedef struct packed {
        logic        isBranch;
        logic [31:0] pc;
        logic [31:0] predTarget;
        logic [31:0] inst;
        logic [5:0]  src1;
        logic [5:0]  src2;
        logic [5:0]  dest;
        logic [35:0] ctrl;
    } decoded_pkt_t;

    // The branch flag is the top bit of every packet.
    localparam int BRANCH_FLAG_BIT = PKT_W - 1;

    typedef logic [PKT_W-1:0] packet_t;

    function automatic logic pktIsBranch(input packet_t p);
        return p[BRANCH_FLAG_BIT];
    endfunction

endpackage

// File: rtl/dispatch_window_reader_ckpt_credit_counter.sv
// Free branch-checkpoint credit pool: debit on accepted windows, credit on releases.
// Latency: 1 cycle, the registered count reflects this cycle's debit/credit next cycle.
// Backpressure: none; the caller only debits when enough credits are present.
module ckpt_credit_counter
    import dispatch_window_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    accept,
    input  logic [BRANCH_CNT_W-1:0] consumeCnt,
    input  logic [BRANCH_CNT_W-1:0] releaseCnt,
    output logic [CKPT_W-1:0]       ckptFree
);

    // One extra bit so a release on a full pool is visible before clamping.
    logic [CKPT_W:0]   sum;
    logic              overflow;
    logic [CKPT_W-1:0] nextFree;

    // Debit and credit applied together, then clamped to the pool size.
    always_comb begin
        sum      = {1'b0, ckptFree}
                   - (accept ? (CKPT_W+1)'(consumeCnt) : '0)
                   + (CKPT_W+1)'(releaseCnt);
        overflow = (sum > (CKPT_W+1)'(CKPT_COUNT));
        nextFree = overflow ? CKPT_W'(CKPT_COUNT) : sum[CKPT_W-1:0];
    end

    // Reset and flush both refill the pool and drop any pending release.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ckptFree <= CKPT_W'(CKPT_COUNT);
        end else begin
            ckptFree <= nextFree;
        end
    end

    // Releasing more checkpoints than were ever taken is an upstream bug.
    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!overflow)
                else $warning("ckpt credit overflow clamped to pool size");
        end
    end

endmodule

// File: rtl/dispatch_window_reader.sv
// Takes a 4-instruction window from the instruction buffer and holds it for rename.
// Latency: 1 cycle from buffer head to windowValid_o; back-to-back windows without bubbles.
// Backpressure: stall_o freezes the buffer head on a full hold register, low credits, or flush.
module dispatch_window_reader
    import dispatch_window_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    instBufferReady_i,
    input  logic [PKT_W-1:0]        decodedPacket0_i,
    input  logic [PKT_W-1:0]        decodedPacket1_i,
    input  logic [PKT_W-1:0]        decodedPacket2_i,
    input  logic [PKT_W-1:0]        decodedPacket3_i,
    input  logic [BRANCH_CNT_W-1:0] branchCount_i,
    input  logic [FREE_W-1:0]       freeRegCnt_i,
    input  logic [BRANCH_CNT_W-1:0] ckptRelease_i,
    input  logic                    consumeReady_i,
    output logic                    stall_o,
    output logic                    windowValid_o,
    output logic [PKT_W-1:0]        decodedPacket0_o,
    output logic [PKT_W-1:0]        decodedPacket1_o,
    output logic [PKT_W-1:0]        decodedPacket2_o,
    output logic [PKT_W-1:0]        decodedPacket3_o,
    output logic [BRANCH_CNT_W-1:0] windowBranchCnt_o,
    output logic [CKPT_W-1:0]       ckptFree_o
);

    logic accept;

    // Stall is independent of instBufferReady_i so the buffer can use it unconditionally;
    // credit checks use the registered pool, so a release never unblocks its own cycle.
    always_comb begin
        stall_o = reset
                | flush_i
                | (windowValid_o & ~consumeReady_i)
                | (freeRegCnt_i < FREE_W'(DISPATCH_WIDTH))
                | (CKPT_W'(branchCount_i) > ckptFree_o);
        accept  = instBufferReady_i & ~stall_o;
    end

    // Hold register: load on accept (replacing a window being consumed), else drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            windowValid_o     <= 1'b0;
            decodedPacket0_o  <= '0;
            decodedPacket1_o  <= '0;
            decodedPacket2_o  <= '0;
            decodedPacket3_o  <= '0;
            windowBranchCnt_o <= '0;
        end else if (flush_i) begin
            windowValid_o <= 1'b0;
        end else if (accept) begin
            windowValid_o     <= 1'b1;
            decodedPacket0_o  <= decodedPacket0_i;
            decodedPacket1_o  <= decodedPacket1_i;
            decodedPacket2_o  <= decodedPacket2_i;
            decodedPacket3_o  <= decodedPacket3_i;
            windowBranchCnt_o <= branchCount_i;
        end else if (consumeReady_i && windowValid_o) begin
            windowValid_o <= 1'b0;
        end
    end

    ckpt_credit_counter u_ckptCredit (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_i),
        .accept     (accept),
        .consumeCnt (branchCount_i),
        .releaseCnt (ckptRelease_i),
        .ckptFree   (ckptFree_o)
    );

    // Held window and credit pool must always stay within architectural limits.
    always @(posedge clk) begin
        if (!reset) begin
            assert (windowBranchCnt_o <= BRANCH_CNT_W'(DISPATCH_WIDTH))
                else $error("windowBranchCnt_o above dispatch width");
            assert (ckptFree_o <= CKPT_W'(CKPT_COUNT))
                else $error("ckptFree_o above pool size");
        end
    end

endmodule

// File: tb/tb_dispatch_window_reader.sv
// Directed table-driven bench for dispatch_window_reader.
// Latency: checks registered outputs 1 cycle after each applied vector.
// Backpressure: drives stall/credit corner cases from hand-computed tables.
module tb_dispatch_window_reader;
    import dispatch_window_reader_pkg::*;

    logic              clk;
    logic              reset;
    logic              flush_i;
    logic              instBufferReady_i;
    logic [PKT_W-1:0]  pktIn [4];
    logic [2:0]        branchCount_i;
    logic [6:0]        freeRegCnt_i;
    logic [2:0]        ckptRelease_i;
    logic              consumeReady_i;
    logic              stall_o;
    logic              windowValid_o;
    logic [PKT_W-1:0]  pktOut [4];
    logic [2:0]        windowBranchCnt_o;
    logic [3:0]        ckptFree_o;

    int total = 0;
    int bad   = 0;

    dispatch_window_reader dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .instBufferReady_i (instBufferReady_i),
        .decodedPacket0_i  (pktIn[0]),
        .decodedPacket1_i  (pktIn[1]),
        .decodedPacket2_i  (pktIn[2]),
        .decodedPacket3_i  (pktIn[3]),
        .branchCount_i     (branchCount_i),
        .freeRegCnt_i      (freeRegCnt_i),
        .ckptRelease_i     (ckptRelease_i),
        .consumeReady_i    (consumeReady_i),
        .stall_o           (stall_o),
        .windowValid_o     (windowValid_o),
        .decodedPacket0_o  (pktOut[0]),
        .decodedPacket1_o  (pktOut[1]),
        .decodedPacket2_o  (pktOut[2]),
        .decodedPacket3_o  (pktOut[3]),
        .windowBranchCnt_o (windowBranchCnt_o),
        .ckptFree_o        (ckptFree_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [2:0] bc;
        logic [6:0] fr;
        logic [2:0] rel;
        logic       cons;
        logic       fl;
        int         id;
        logic       expStall;
        logic       expV;
        int         expId;
        logic [2:0] expB;
        logic [3:0] expC;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input int bc, input int fr, input int rel,
                                input logic cons, input logic fl, input int id,
                                input logic expStall, input logic expV, input int expId,
                                input int expB, input int expC);
        vec_t v;
        v.rdy = rdy; v.bc = 3'(bc); v.fr = 7'(fr); v.rel = 3'(rel);
        v.cons = cons; v.fl = fl; v.id = id;
        v.expStall = expStall; v.expV = expV; v.expId = expId;
        v.expB = 3'(expB); v.expC = 4'(expC);
        return v;
    endfunction

    // Distinct recognisable pattern per window id and lane; id < 0 means all zero.
    function automatic logic [PKT_W-1:0] mkPkt(input int id, input int lane);
        logic [7:0]   b;
        logic [151:0] w;
        if (id < 0) return '0;
        b = 8'(id * 16 + lane);
        w = {19{b}};
        return w[PKT_W-1:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkPkts(input string nm, input int id);
        for (int l = 0; l < 4; l++) begin
            logic [PKT_W-1:0] e;
            e = mkPkt(id, l);
            total++;
            if (pktOut[l] !== e) begin
                bad++;
                $display("FAIL %s_pkt%0d: got %h expected %h", nm, l, pktOut[l], e);
            end
        end
    endtask

    task automatic drive(input logic rdy, input int bc, input int fr, input int rel,
                         input logic cons, input logic fl, input int id);
        instBufferReady_i = rdy;
        branchCount_i     = 3'(bc);
        freeRegCnt_i      = 7'(fr);
        ckptRelease_i     = 3'(rel);
        consumeReady_i    = cons;
        flush_i           = fl;
        for (int l = 0; l < 4; l++) pktIn[l] = mkPkt(id, l);
    endtask

    task automatic applyVec(input vec_t v, input int n);
        @(negedge clk);
        drive(v.rdy, int'(v.bc), int'(v.fr), int'(v.rel), v.cons, v.fl, v.id);
        #1;
        chk($sformatf("v%0d_stall", n), int'(stall_o), int'(v.expStall));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", n), int'(windowValid_o), int'(v.expV));
        chk($sformatf("v%0d_ckpt", n), int'(ckptFree_o), int'(v.expC));
        if (v.expV) begin
            chk($sformatf("v%0d_bcnt", n), int'(windowBranchCnt_o), int'(v.expB));
            chkPkts($sformatf("v%0d", n), v.expId);
        end
    endtask

    initial begin
        //            rdy bc fr  rel cons fl id | stall V  id  B  C
        vecs.push_back(mk(1, 2, 20, 0, 1, 0, 1,   0, 1,  1, 2, 6));  // first accept
        vecs.push_back(mk(1, 1, 20, 0, 0, 0, 2,   1, 1,  1, 2, 6));  // held, no consume
        vecs.push_back(mk(1, 1, 20, 0, 0, 0, 2,   1, 1,  1, 2, 6));  // still stable
        vecs.push_back(mk(1, 1, 20, 0, 1, 0, 3,   0, 1,  3, 1, 5));  // back-to-back replace
        vecs.push_back(mk(0, 0, 20, 0, 1, 0, 4,   0, 0,  3, 1, 5));  // drain, no ready
        vecs.push_back(mk(0, 0, 20, 0, 0, 0, 4,   0, 0,  3, 1, 5));  // idle
        vecs.push_back(mk(1, 4, 20, 0, 1, 0, 5,   0, 1,  5, 4, 1));  // ckptFree -> 1
        vecs.push_back(mk(1, 3, 20, 0, 1, 0, 6,   1, 0,  5, 4, 1));  // 3 > 1: stall, drain
        vecs.push_back(mk(1, 3, 20, 0, 1, 0, 6,   1, 0,  5, 4, 1));
        vecs.push_back(mk(1, 3, 20, 2, 1, 0, 6,   1, 0,  5, 4, 3));  // release can't unblock now
        vecs.push_back(mk(1, 3, 20, 0, 1, 0, 6,   0, 1,  6, 3, 0));  // accept next cycle
        vecs.push_back(mk(1, 0, 3,  0, 1, 0, 7,   1, 0,  6, 3, 0));  // freeReg 3 stalls
        vecs.push_back(mk(1, 0, 4,  0, 1, 0, 7,   0, 1,  7, 0, 0));  // freeReg 4 accepts
        vecs.push_back(mk(0, 0, 20, 5, 0, 0, 7,   1, 1,  7, 0, 5));  // ckptFree -> 5, held
        vecs.push_back(mk(1, 1, 20, 2, 1, 1, 8,   1, 0,  7, 0, 8));  // flush mid-hold
        vecs.push_back(mk(1, 4, 20, 0, 1, 0, 9,   0, 1,  9, 4, 4));  // ckptFree -> 4
        vecs.push_back(mk(1, 4, 20, 3, 1, 0, 10,  0, 1, 10, 4, 3));  // accept 4 + release 3
        vecs.push_back(mk(0, 0, 20, 5, 1, 0, 10,  0, 0, 10, 4, 8));  // refill to 8
        vecs.push_back(mk(0, 0, 20, 7, 0, 0, 10,  0, 0, 10, 4, 8));  // overflow clamps

        // Reset sequence
        reset = 1'b1;
        drive(1'b0, 0, 20, 0, 1'b0, 1'b0, -1);
        @(negedge clk);
        #1;
        chk("rst_stall", int'(stall_o), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", int'(windowValid_o), 0);
        chk("rst_bcnt", int'(windowBranchCnt_o), 0);
        chk("rst_ckpt", int'(ckptFree_o), 8);
        chk("rst_idle_stall", int'(stall_o), 0);
        chkPkts("rst", -1);

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

        // Reset mid-run after credits were taken
        @(negedge clk);
        drive(1'b1, 2, 20, 0, 1'b1, 1'b0, 11);
        @(posedge clk);
        #1;
        chk("mr_valid", int'(windowValid_o), 1);
        chk("mr_ckpt", int'(ckptFree_o), 6);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1, 20, 3, 1'b1, 1'b0, 12);
        #1;
        chk("mr_rst_stall", int'(stall_o), 1);
        @(posedge clk);
        #1;
        chk("mr_rst_valid", int'(windowValid_o), 0);
        chk("mr_rst_ckpt", int'(ckptFree_o), 8);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1, 20, 0, 1'b1, 1'b0, 13);
        #1;
        chk("mr_post_stall", int'(stall_o), 0);
        @(posedge clk);
        #1;
        chk("mr_post_valid", int'(windowValid_o), 1);
        chk("mr_post_ckpt", int'(ckptFree_o), 7);
        chk("mr_post_bcnt", int'(windowBranchCnt_o), 1);
        chkPkts("mr_post", 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
